// File: rtl/riscv_pkg.sv
// Shared constants and types for the memory-side blocks of the RISC-V core.
// Line geometry, arbiter state encoding and watchdog sizing live here.
package riscv_pkg;

    localparam int LINE_WIDTH      = 128;
    localparam int LINE_ADDR_WIDTH = 23;
    localparam int MEMARB_TIMEOUT  = 1024;

    typedef enum logic [1:0] {
        MEMARB_IDLE    = 2'd0,
        MEMARB_DC_XFER = 2'd1,
        MEMARB_IC_XFER = 2'd2
    } memarb_state_e;

    // Side that wins the next contested grant.
    typedef enum logic {
        RR_DC = 1'b0,
        RR_IC = 1'b1
    } memarb_side_e;

    // Counter width able to hold TIMEOUT-1, never narrower than one bit.
    function automatic int wdog_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/riscv_memarb_wdog.sv
// Transfer watchdog: saturating cycle counter plus a sticky error flag.
// The owner decides when the counter is at its limit and drives hit.
module riscv_memarb_wdog #(
    parameter int CW = 10
) (
    input  logic          i_riscv_memarb_clk,
    input  logic          i_riscv_memarb_rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          hit,
    output logic [CW-1:0] count,
    output logic          flag
);

    logic [CW-1:0] count_reg;
    logic          flag_reg;

    always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
        if (!i_riscv_memarb_rst_n) begin
            count_reg <= '0;
            flag_reg  <= 1'b0;
        end else begin
            // Holding at the limit keeps hit asserted for a stalled transfer.
            if (clr)
                count_reg <= '0;
            else if (en && !hit)
                count_reg <= count_reg + CW'(1);
            if (en && hit)
                flag_reg <= 1'b1;
        end
    end

    assign count = count_reg;
    assign flag  = flag_reg;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares the single DDR line port between icache refills and dcache refill/write-back.
// One transaction in flight, round-robin with a write-back lock, plus a stall watchdog.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = LINE_WIDTH,
    parameter int S_ADDR     = LINE_ADDR_WIDTH,
    parameter int TIMEOUT    = MEMARB_TIMEOUT
) (
    input  logic                  i_riscv_memarb_clk,
    input  logic                  i_riscv_memarb_rst_n,
    input  logic                  i_riscv_memarb_dc_rden,
    input  logic                  i_riscv_memarb_dc_wren,
    input  logic [S_ADDR-1:0]     i_riscv_memarb_dc_addr,
    input  logic [DATA_WIDTH-1:0] i_riscv_memarb_dc_wdata,
    output logic                  o_riscv_memarb_dc_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_memarb_dc_rdata,
    input  logic                  i_riscv_memarb_ic_rden,
    input  logic [S_ADDR-1:0]     i_riscv_memarb_ic_addr,
    output logic                  o_riscv_memarb_ic_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_memarb_ic_rdata,
    output logic                  o_riscv_memarb_mem_rden,
    output logic                  o_riscv_memarb_mem_wren,
    output logic [S_ADDR-1:0]     o_riscv_memarb_mem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_memarb_mem_wdata,
    input  logic                  i_riscv_memarb_mem_ready,
    input  logic [DATA_WIDTH-1:0] i_riscv_memarb_mem_rdata,
    output logic                  o_riscv_memarb_timeout
);

    localparam int CW = wdog_width(TIMEOUT);

    memarb_state_e         state_reg, state_next;
    memarb_side_e          rr_reg;
    logic                  lock_reg;
    logic                  mem_rden_reg, mem_wren_reg;
    logic [S_ADDR-1:0]     mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;

    logic          dc_req, grant_dc, grant_ic, xfer, done;
    logic [CW-1:0] wdog_count;
    logic          wdog_hit, wdog_flag;

    assign dc_req = i_riscv_memarb_dc_rden | i_riscv_memarb_dc_wren;
    assign xfer   = (state_reg != MEMARB_IDLE);
    assign done   = xfer & i_riscv_memarb_mem_ready;

    // A pending write-back lock outranks the round-robin pointer for the refill.
    always_comb begin
        grant_dc = 1'b0;
        grant_ic = 1'b0;
        if (state_reg == MEMARB_IDLE) begin
            if (lock_reg && i_riscv_memarb_dc_rden)
                grant_dc = 1'b1;
            else if (dc_req && i_riscv_memarb_ic_rden) begin
                if (rr_reg == RR_DC)
                    grant_dc = 1'b1;
                else
                    grant_ic = 1'b1;
            end else if (dc_req)
                grant_dc = 1'b1;
            else if (i_riscv_memarb_ic_rden)
                grant_ic = 1'b1;
        end
    end

    always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
        if (!i_riscv_memarb_rst_n)
            state_reg <= MEMARB_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MEMARB_IDLE: begin
                if (grant_dc)
                    state_next = MEMARB_DC_XFER;
                else if (grant_ic)
                    state_next = MEMARB_IC_XFER;
            end
            MEMARB_DC_XFER, MEMARB_IC_XFER: begin
                if (i_riscv_memarb_mem_ready)
                    state_next = MEMARB_IDLE;
            end
            default: state_next = MEMARB_IDLE;
        endcase
    end

    always_comb begin
        o_riscv_memarb_dc_ready = 1'b0;
        o_riscv_memarb_dc_rdata = '0;
        o_riscv_memarb_ic_ready = 1'b0;
        o_riscv_memarb_ic_rdata = '0;
        if (state_reg == MEMARB_DC_XFER) begin
            o_riscv_memarb_dc_ready = i_riscv_memarb_mem_ready;
            o_riscv_memarb_dc_rdata = i_riscv_memarb_mem_rdata;
        end
        if (state_reg == MEMARB_IC_XFER) begin
            o_riscv_memarb_ic_ready = i_riscv_memarb_mem_ready;
            o_riscv_memarb_ic_rdata = i_riscv_memarb_mem_rdata;
        end
    end

    // Request fields are captured once at grant; the requester is not re-sampled mid-transfer.
    always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
        if (!i_riscv_memarb_rst_n) begin
            rr_reg        <= RR_DC;
            lock_reg      <= 1'b0;
            mem_rden_reg  <= 1'b0;
            mem_wren_reg  <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else if (grant_dc) begin
            rr_reg        <= RR_IC;
            lock_reg      <= 1'b0;
            mem_rden_reg  <= ~i_riscv_memarb_dc_wren;
            mem_wren_reg  <= i_riscv_memarb_dc_wren;
            mem_addr_reg  <= i_riscv_memarb_dc_addr;
            mem_wdata_reg <= i_riscv_memarb_dc_wdata;
        end else if (grant_ic) begin
            rr_reg        <= RR_DC;
            lock_reg      <= 1'b0;
            mem_rden_reg  <= 1'b1;
            mem_wren_reg  <= 1'b0;
            mem_addr_reg  <= i_riscv_memarb_ic_addr;
            mem_wdata_reg <= '0;
        end else if (done) begin
            mem_rden_reg  <= 1'b0;
            mem_wren_reg  <= 1'b0;
            lock_reg      <= (state_reg == MEMARB_DC_XFER) & mem_wren_reg;
        end
    end

    assign o_riscv_memarb_mem_rden  = mem_rden_reg;
    assign o_riscv_memarb_mem_wren  = mem_wren_reg;
    assign o_riscv_memarb_mem_addr  = mem_addr_reg;
    assign o_riscv_memarb_mem_wdata = mem_wdata_reg;

    assign wdog_hit = (wdog_count == CW'(TIMEOUT - 1));

    riscv_memarb_wdog #(
        .CW (CW)
    ) u_wdog (
        .i_riscv_memarb_clk   (i_riscv_memarb_clk),
        .i_riscv_memarb_rst_n (i_riscv_memarb_rst_n),
        .clr                  (grant_dc | grant_ic),
        .en                   (xfer & ~i_riscv_memarb_mem_ready),
        .hit                  (wdog_hit),
        .count                (wdog_count),
        .flag                 (wdog_flag)
    );

    assign o_riscv_memarb_timeout = wdog_flag;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scenario bench for riscv_mem_arbiter: a bench-side memory serves each grant while a
// scoreboard of expected transactions is compared against what the arbiter issued.
module tb_riscv_mem_arbiter;

    localparam int DW = 128;
    localparam int AW = 23;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dc_rden = 1'b0, dc_wren = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [DW-1:0] dc_wdata = '0;
    logic          dc_ready;
    logic [DW-1:0] dc_rdata;
    logic          ic_rden = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_ready;
    logic [DW-1:0] ic_rdata;
    logic          mem_rden, mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          timeout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic          dc_follow = 1'b0;
    logic [AW-1:0] dc_follow_addr = '0;

    typedef struct {
        bit            dc;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            gap;
    } exp_t;

    typedef struct {
        bit            found;
        bit            dc;
        bit            wr;
        bit            rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            clean;
        int            s_cyc;
        int            gap;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];

    riscv_mem_arbiter #(
        .DATA_WIDTH (DW),
        .S_ADDR     (AW),
        .TIMEOUT    (TO)
    ) dut (
        .i_riscv_memarb_clk       (clk),
        .i_riscv_memarb_rst_n     (rst_n),
        .i_riscv_memarb_dc_rden   (dc_rden),
        .i_riscv_memarb_dc_wren   (dc_wren),
        .i_riscv_memarb_dc_addr   (dc_addr),
        .i_riscv_memarb_dc_wdata  (dc_wdata),
        .o_riscv_memarb_dc_ready  (dc_ready),
        .o_riscv_memarb_dc_rdata  (dc_rdata),
        .i_riscv_memarb_ic_rden   (ic_rden),
        .i_riscv_memarb_ic_addr   (ic_addr),
        .o_riscv_memarb_ic_ready  (ic_ready),
        .o_riscv_memarb_ic_rdata  (ic_rdata),
        .o_riscv_memarb_mem_rden  (mem_rden),
        .o_riscv_memarb_mem_wren  (mem_wren),
        .o_riscv_memarb_mem_addr  (mem_addr),
        .o_riscv_memarb_mem_wdata (mem_wdata),
        .i_riscv_memarb_mem_ready (mem_ready),
        .i_riscv_memarb_mem_rdata (mem_rdata),
        .o_riscv_memarb_timeout   (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    // Contents of the bench memory: one distinctive line per address.
    function automatic logic [DW-1:0] mem_line(input logic [AW-1:0] a);
        if (a == 23'h12345)
            return {16{8'hA5}};
        return {4{{9'd0, a}}};
    endfunction

    function automatic exp_t mk(input bit dc, input bit wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int gap);
        exp_t e;
        e.dc = dc; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd; e.gap = gap;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dc_rden = 0; dc_wren = 0; ic_rden = 0; dc_follow = 0;
        mem_ready = 0; mem_rdata = '0;
        rst_n = 0; step(); step();
        rst_n = 1; step();
    endtask

    // Memory side plus requester behaviour: answer n grants after lat cycles each.
    task automatic service(input int n, input int lat);
        int prev_r = -1;
        for (int t = 0; t < n; t++) begin
            obs_t o;
            int   w;
            w = 0;
            o.found = 0; o.dc = 0; o.wr = 0; o.rd = 0; o.addr = '0; o.wdata = '0;
            o.rdata = '0; o.clean = 1; o.s_cyc = 0; o.gap = -1;
            while (!(mem_rden || mem_wren) && w < 64) begin
                step();
                w++;
            end
            o.found = mem_rden || mem_wren;
            if (!o.found) begin
                obs_q.push_back(o);
                return;
            end
            o.s_cyc = cyc; o.wr = mem_wren; o.rd = mem_rden;
            o.addr = mem_addr; o.wdata = mem_wdata;
            o.gap = (prev_r < 0) ? -1 : cyc - prev_r;
            for (int k = 0; k < lat; k++) begin
                if (dc_ready || ic_ready || !(mem_rden || mem_wren)) o.clean = 0;
                step();
            end
            mem_ready = 1;
            mem_rdata = mem_line(mem_addr);
            #1;
            o.dc = dc_ready;
            o.rdata = dc_ready ? dc_rdata : ic_rdata;
            if (dc_ready == ic_ready) o.clean = 0;
            if (dc_ready && ic_rdata !== '0) o.clean = 0;
            if (ic_ready && dc_rdata !== '0) o.clean = 0;
            if (!(mem_rden || mem_wren)) o.clean = 0;
            prev_r = cyc;
            if (dc_ready) begin
                if (mem_wren) begin
                    dc_wren = 0;
                    if (dc_follow) begin
                        dc_rden = 1; dc_addr = dc_follow_addr; dc_follow = 0;
                    end
                end else begin
                    dc_rden = 0;
                end
            end
            if (ic_ready) ic_rden = 0;
            obs_q.push_back(o);
            step();
            mem_ready = 0;
            mem_rdata = '0;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; step(); step();
        checks++;
        if ({mem_rden, mem_wren, dc_ready, ic_ready, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000", {mem_rden, mem_wren, dc_ready, ic_ready, timeout});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h required 0", mem_addr, mem_wdata);
        end
        checks++;
        if (dc_rdata !== '0 || ic_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got dc %h ic %h required 0", dc_rdata, ic_rdata);
        end
        rst_n = 1; step();
        dc_addr = 23'h00333; dc_rden = 1; step();
        checks++;
        if (mem_rden !== 1'b1 || mem_addr !== 23'h00333) begin
            errors++;
            $display("FAIL reset_pre_grant: got rden %b addr %h required 1 00333", mem_rden, mem_addr);
        end
        step(); step();
        rst_n = 0; #1;
        checks++;
        if ({mem_rden, mem_wren} !== 2'b00) begin
            errors++;
            $display("FAIL reset_async_drop: got %b required 00", {mem_rden, mem_wren});
        end
        dc_rden = 0; step();
        rst_n = 1; step(); step();
        checks++;
        if ({mem_rden, mem_wren, dc_ready, timeout} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle_after: got %b required 0000", {mem_rden, mem_wren, dc_ready, timeout});
        end
        ic_addr = 23'h00444; ic_rden = 1; step();
        checks++;
        if (mem_rden !== 1'b1 || mem_addr !== 23'h00444) begin
            errors++;
            $display("FAIL reset_regrant: got rden %b addr %h required 1 00444", mem_rden, mem_addr);
        end
        mem_ready = 1; mem_rdata = mem_line(23'h00444); #1;
        checks++;
        if (ic_ready !== 1'b1 || ic_rdata !== mem_line(23'h00444)) begin
            errors++;
            $display("FAIL reset_regrant_ready: got ready %b rdata %h", ic_ready, ic_rdata);
        end
        $display("reset txn: icache read 00444 after mid-transfer reset");
        ic_rden = 0; step();
        mem_ready = 0; mem_rdata = '0; step();
    endtask

    task automatic test_ic_read();
        exp_t e;
        obs_t o;
        int   n;
        do_reset();
        ic_addr = 23'h12345; ic_rden = 1; n = cyc;
        exp_q.push_back(mk(0, 0, 23'h12345, '0, {16{8'hA5}}, -1));
        service(1, 5);
        if (obs_q.size() != 0) begin
            checks++;
            if (obs_q[0].s_cyc != n + 1) begin
                errors++;
                $display("FAIL ic_latency: strobe at cycle %0d required %0d", obs_q[0].s_cyc, n + 1);
            end
        end
        checks++;
        if ({mem_rden, mem_wren} !== 2'b00) begin
            errors++;
            $display("FAIL ic_strobe_clear: got %b required 00", {mem_rden, mem_wren});
        end
        mem_ready = 1; mem_rdata = '1; #1;
        checks++;
        if ({dc_ready, ic_ready} !== 2'b00 || dc_rdata !== '0 || ic_rdata !== '0) begin
            errors++;
            $display("FAIL idle_ready_ignored: got ready %b dc %h ic %h required 0", {dc_ready, ic_ready}, dc_rdata, ic_rdata);
        end
        step(); mem_ready = 0; mem_rdata = '0;
        checks++;
        if ({mem_rden, mem_wren} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_grant: got %b required 00", {mem_rden, mem_wren});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0 || !obs_q[0].found) begin
                errors++;
                $display("FAIL ic_read_missing: got no strobe, required addr %h", e.addr);
                if (obs_q.size() != 0) obs_q.delete();
            end else begin
                o = obs_q.pop_front();
                $display("ic_read txn: dc=%0d wr=%0d rd=%0d addr=%h", o.dc, o.wr, o.rd, o.addr);
                checks++;
                if ({o.dc, o.wr, o.rd} !== {e.dc, e.wr, !e.wr}) begin
                    errors++;
                    $display("FAIL ic_read_kind: got dc/wr/rd %b%b%b required %b%b%b", o.dc, o.wr, o.rd, e.dc, e.wr, !e.wr);
                end
                checks++;
                if (o.addr !== e.addr) begin
                    errors++;
                    $display("FAIL ic_read_addr: got %h required %h", o.addr, e.addr);
                end
                checks++;
                if (o.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL ic_read_rdata: got %h required %h", o.rdata, e.rdata);
                end
                checks++;
                if (!o.clean) begin
                    errors++;
                    $display("FAIL ic_read_steering: got stray or missing ready, required single ic pulse");
                end
            end
        end
    endtask

    task automatic test_alternation();
        exp_t e;
        obs_t o;
        do_reset();
        dc_addr = 23'h00400; dc_rden = 1; ic_addr = 23'h00500; ic_rden = 1;
        exp_q.push_back(mk(1, 0, 23'h00400, '0, mem_line(23'h00400), -1));
        exp_q.push_back(mk(0, 0, 23'h00500, '0, mem_line(23'h00500), 2));
        service(2, 3);
        dc_addr = 23'h00600; dc_rden = 1;
        exp_q.push_back(mk(1, 0, 23'h00600, '0, mem_line(23'h00600), -1));
        service(1, 2);
        dc_addr = 23'h00700; dc_rden = 1; ic_addr = 23'h00800; ic_rden = 1;
        exp_q.push_back(mk(0, 0, 23'h00800, '0, mem_line(23'h00800), -1));
        exp_q.push_back(mk(1, 0, 23'h00700, '0, mem_line(23'h00700), 2));
        service(2, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0 || !obs_q[0].found) begin
                errors++;
                $display("FAIL alt_missing: got no strobe, required addr %h", e.addr);
                if (obs_q.size() != 0) void'(obs_q.pop_front());
            end else begin
                o = obs_q.pop_front();
                $display("alternation txn: dc=%0d wr=%0d rd=%0d addr=%h gap=%0d", o.dc, o.wr, o.rd, o.addr, o.gap);
                checks++;
                if ({o.dc, o.wr, o.rd} !== {e.dc, e.wr, !e.wr}) begin
                    errors++;
                    $display("FAIL alt_kind: got dc/wr/rd %b%b%b required %b%b%b", o.dc, o.wr, o.rd, e.dc, e.wr, !e.wr);
                end
                checks++;
                if (o.addr !== e.addr) begin
                    errors++;
                    $display("FAIL alt_addr: got %h required %h", o.addr, e.addr);
                end
                checks++;
                if (o.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL alt_rdata: got %h required %h", o.rdata, e.rdata);
                end
                checks++;
                if (!o.clean) begin
                    errors++;
                    $display("FAIL alt_steering: got stray or missing ready for addr %h", o.addr);
                end
                if (e.gap >= 0) begin
                    checks++;
                    if (o.gap != e.gap) begin
                        errors++;
                        $display("FAIL alt_gap: got %0d cycles required %0d", o.gap, e.gap);
                    end
                end
            end
        end
    endtask

    task automatic test_lock();
        exp_t e;
        obs_t o;
        logic [DW-1:0] w1;
        w1 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
        do_reset();
        dc_addr = 23'h00100; dc_wdata = w1; dc_wren = 1;
        ic_addr = 23'h00900; ic_rden = 1;
        dc_follow = 1; dc_follow_addr = 23'h00200;
        exp_q.push_back(mk(1, 1, 23'h00100, w1, '0, -1));
        exp_q.push_back(mk(1, 0, 23'h00200, '0, mem_line(23'h00200), 2));
        exp_q.push_back(mk(0, 0, 23'h00900, '0, mem_line(23'h00900), 2));
        service(3, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0 || !obs_q[0].found) begin
                errors++;
                $display("FAIL lock_missing: got no strobe, required addr %h", e.addr);
                if (obs_q.size() != 0) void'(obs_q.pop_front());
            end else begin
                o = obs_q.pop_front();
                $display("lock txn: dc=%0d wr=%0d rd=%0d addr=%h gap=%0d", o.dc, o.wr, o.rd, o.addr, o.gap);
                checks++;
                if ({o.dc, o.wr, o.rd} !== {e.dc, e.wr, !e.wr}) begin
                    errors++;
                    $display("FAIL lock_kind: got dc/wr/rd %b%b%b required %b%b%b", o.dc, o.wr, o.rd, e.dc, e.wr, !e.wr);
                end
                checks++;
                if (o.addr !== e.addr) begin
                    errors++;
                    $display("FAIL lock_addr: got %h required %h", o.addr, e.addr);
                end
                checks++;
                if (e.wr ? (o.wdata !== e.wdata) : (o.rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL lock_data: got w %h r %h required %h", o.wdata, o.rdata, e.wr ? e.wdata : e.rdata);
                end
                checks++;
                if (!o.clean) begin
                    errors++;
                    $display("FAIL lock_steering: got stray or missing ready for addr %h", o.addr);
                end
                if (e.gap >= 0) begin
                    checks++;
                    if (o.gap != e.gap) begin
                        errors++;
                        $display("FAIL lock_gap: got %0d cycles required %0d", o.gap, e.gap);
                    end
                end
            end
        end
    endtask

    task automatic test_write_first();
        exp_t e;
        obs_t o;
        logic [DW-1:0] w2;
        w2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FACE_B00C;
        do_reset();
        dc_addr = 23'h00ABC; dc_wdata = w2; dc_wren = 1; dc_rden = 1;
        exp_q.push_back(mk(1, 1, 23'h00ABC, w2, '0, -1));
        exp_q.push_back(mk(1, 0, 23'h00ABC, '0, mem_line(23'h00ABC), 2));
        service(2, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0 || !obs_q[0].found) begin
                errors++;
                $display("FAIL wfirst_missing: got no strobe, required addr %h", e.addr);
                if (obs_q.size() != 0) void'(obs_q.pop_front());
            end else begin
                o = obs_q.pop_front();
                $display("write_first txn: dc=%0d wr=%0d rd=%0d addr=%h gap=%0d", o.dc, o.wr, o.rd, o.addr, o.gap);
                checks++;
                if ({o.dc, o.wr, o.rd} !== {e.dc, e.wr, !e.wr}) begin
                    errors++;
                    $display("FAIL wfirst_kind: got dc/wr/rd %b%b%b required %b%b%b", o.dc, o.wr, o.rd, e.dc, e.wr, !e.wr);
                end
                checks++;
                if (o.addr !== e.addr) begin
                    errors++;
                    $display("FAIL wfirst_addr: got %h required %h", o.addr, e.addr);
                end
                checks++;
                if (e.wr ? (o.wdata !== e.wdata) : (o.rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL wfirst_data: got w %h r %h required %h", o.wdata, o.rdata, e.wr ? e.wdata : e.rdata);
                end
                checks++;
                if (!o.clean) begin
                    errors++;
                    $display("FAIL wfirst_steering: got stray or missing ready for addr %h", o.addr);
                end
                if (e.gap >= 0) begin
                    checks++;
                    if (o.gap != e.gap) begin
                        errors++;
                        $display("FAIL wfirst_gap: got %0d cycles required %0d", o.gap, e.gap);
                    end
                end
            end
        end
    endtask

    task automatic test_timeout();
        int w;
        do_reset();
        ic_addr = 23'h07777; ic_rden = 1;
        w = 0;
        while (!mem_rden && w < 20) begin
            step();
            w++;
        end
        checks++;
        if (mem_rden !== 1'b1) begin
            errors++;
            $display("FAIL wdog_grant: got rden %b required 1", mem_rden);
        end
        // Now in transfer cycle 1; cycle 16 must still be clean, cycle 17 flagged.
        for (int k = 0; k < 15; k++) step();
        checks++;
        if (timeout !== 1'b0 || mem_rden !== 1'b1) begin
            errors++;
            $display("FAIL wdog_early: got timeout %b rden %b required 0 1", timeout, mem_rden);
        end
        step();
        checks++;
        if (timeout !== 1'b1 || mem_rden !== 1'b1) begin
            errors++;
            $display("FAIL wdog_rise: got timeout %b rden %b required 1 1", timeout, mem_rden);
        end
        step(); step(); step();
        mem_ready = 1; mem_rdata = mem_line(23'h07777); #1;
        checks++;
        if (ic_ready !== 1'b1 || ic_rdata !== mem_line(23'h07777)) begin
            errors++;
            $display("FAIL wdog_late_ready: got ready %b rdata %h", ic_ready, ic_rdata);
        end
        $display("timeout txn: icache read 07777 completed after watchdog fired");
        ic_rden = 0; step();
        mem_ready = 0; mem_rdata = '0; step();
        checks++;
        if (timeout !== 1'b1 || mem_rden !== 1'b0) begin
            errors++;
            $display("FAIL wdog_sticky: got timeout %b rden %b required 1 0", timeout, mem_rden);
        end
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_alternation();
        test_lock();
        test_write_first();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
